// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a selected pattern out MSB-first,
// optionally repeated with zero-filled gaps, as a detector stimulus source.
module serial_pattern_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic [7:0]       req_custom,
    input  logic [CNT_W-1:0] req_rpt,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       sreg, sreg_nxt;
    logic [7:0]       pat_q, pat_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [2:0]       len_q, len_nxt;
    logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [7:0]       sel_pat;
    logic [2:0]       sel_len;

    // Left-align the requested pattern; length is stored as bits minus one
    always_comb begin
        sel_pat = req_custom;
        sel_len = 3'd7;
        unique case (req_sel)
            2'd0: begin sel_pat = 8'hC0; sel_len = 3'd1; end
            2'd1: begin sel_pat = 8'hA0; sel_len = 3'd2; end
            2'd2: begin sel_pat = 8'hB0; sel_len = 3'd3; end
            2'd3: begin sel_pat = req_custom; sel_len = 3'd7; end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers: shifter, captured pattern and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            pat_q   <= '0;
            bit_cnt <= '0;
            len_q   <= '0;
            rpt_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            sreg    <= sreg_nxt;
            pat_q   <= pat_nxt;
            bit_cnt <= bit_nxt;
            len_q   <= len_nxt;
            rpt_cnt <= rpt_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        pat_nxt   = pat_q;
        bit_nxt   = bit_cnt;
        len_nxt   = len_q;
        rpt_nxt   = rpt_cnt;
        gap_nxt   = gap_cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SHIFT;
                    pat_nxt   = sel_pat;
                    len_nxt   = sel_len;
                    sreg_nxt  = sel_pat;
                    bit_nxt   = sel_len;
                    rpt_nxt   = req_rpt;
                end
            end
            SHIFT: begin
                if (bit_cnt != 3'd0) begin
                    sreg_nxt = {sreg[6:0], 1'b0};
                    bit_nxt  = bit_cnt - 3'd1;
                end else if (rpt_cnt != '0) begin
                    rpt_nxt = rpt_cnt - CNT_W'(1);
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        sreg_nxt = pat_q;
                        bit_nxt  = len_q;
                    end
                end else begin
                    state_nxt = DONE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = pat_q;
                    bit_nxt   = len_q;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign ser_en    = (state == SHIFT);
    assign ser_out   = (state == SHIFT) & sreg[7];

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: table vectors, random requests against a
// trace model, reset abort and back-to-back loopback sequences.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_sel = '0;
    logic [7:0] req_custom = '0;
    logic [3:0] req_rpt = '0;
    logic       ser_out, ser_en, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] cus;
        int         rpt;
        int         span;
    } vec_t;

    vec_t       tbl[5];
    logic [4:0] exp_q[$];

    serial_pattern_tx #(.GAP_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_sel(req_sel),
        .req_custom(req_custom),
        .req_rpt(req_rpt),
        .ser_out(ser_out),
        .ser_en(ser_en),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    wire [4:0] obs = {req_ready, busy, done, ser_en, ser_out};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {ready,busy,done,en,out} per cycle after the accept edge
    task automatic build(input logic [1:0] sel, input logic [7:0] cus,
                         input int rpt);
        int         len;
        logic [7:0] p;
        exp_q.delete();
        case (sel)
            2'd0: begin p = 8'b11;   len = 2; end
            2'd1: begin p = 8'b101;  len = 3; end
            2'd2: begin p = 8'b1011; len = 4; end
            default: begin p = cus;  len = 8; end
        endcase
        for (int n = 0; n <= rpt; n++) begin
            for (int j = 0; j < len; j++)
                exp_q.push_back({4'b0101, p[len-1-j]});
            if (n < rpt)
                for (int g = 0; g < 2; g++) exp_q.push_back(5'b01000);
        end
        exp_q.push_back(5'b01100);
        exp_q.push_back(5'b10000);
    endtask

    task automatic run(input logic [1:0] sel, input logic [7:0] cus,
                       input int rpt, input bit noise, output int span);
        @(negedge clk);
        req_valid  = 1'b1;
        req_sel    = sel;
        req_custom = cus;
        req_rpt    = 4'(rpt);
        check("ready_before_req", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        build(sel, cus, rpt);
        span = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("trace sel%0d rpt%0d c%0d", sel, rpt, i),
                  obs, exp_q[i]);
            if (busy) span++;
            if (noise && i < exp_q.size() - 1) begin
                req_valid  = 1'($urandom);
                req_sel    = 2'($urandom);
                req_custom = 8'($urandom);
                req_rpt    = 4'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         span;
        int         hist;
        int         det;
        logic [4:0] b2b[8];
        logic [1:0] rs;
        logic [7:0] rc;
        int         rr, len;

        tbl[0] = '{2'd1, 8'h00, 0, 4};
        tbl[1] = '{2'd2, 8'h00, 1, 11};
        tbl[2] = '{2'd3, 8'hA5, 0, 9};
        tbl[3] = '{2'd3, 8'h00, 0, 9};
        tbl[4] = '{2'd0, 8'h00, 15, 63};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", obs, 5'b10000);

        foreach (tbl[k]) begin
            run(tbl[k].sel, tbl[k].cus, tbl[k].rpt, 1'b0, span);
            check($sformatf("busy_span vec%0d", k), span, tbl[k].span);
        end

        for (int k = 0; k < 10; k++) begin
            rs = 2'($urandom);
            rc = 8'($urandom);
            rr = $urandom_range(0, 3);
            len = (rs == 2'd3) ? 8 : int'(rs) + 2;
            run(rs, rc, rr, 1'b1, span);
            check($sformatf("rand_span %0d", k), span,
                  (rr + 1) * len + rr * 2 + 1);
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 2'd2;
        req_rpt   = 4'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_bit0", obs, 5'b01011);
        @(negedge clk);
        check("abort_bit1", obs, 5'b01010);
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle", obs, 5'b10000);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", obs, 5'b10000);
        run(2'd0, 8'h00, 0, 1'b0, span);
        check("after_abort_span", span, 3);

        b2b = '{5'b01011, 5'b01011, 5'b01100, 5'b10000,
                5'b01011, 5'b01011, 5'b01100, 5'b10000};
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 2'd0;
        req_rpt   = 4'd0;
        @(posedge clk);
        hist = 0;
        det  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b c%0d", i), obs, b2b[i]);
            hist = ((hist << 1) | int'(ser_out)) & 3;
            if (hist == 3) det++;
            if (i == 6) req_valid = 1'b0;
        end
        check("loopback_11_detects", det, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
